// File: rtl/truth_table_sweeper.sv
// Sweeps a combinational block through every input vector, captures its truth
// table and scores it against an expected table.
module truth_table_sweeper #(
  parameter int                    N_IN   = 4,
  parameter int                    SETTLE = 2,
  parameter logic [2**N_IN-1:0]    EXPECT = 16'h7310
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic                s_in,
  output logic [N_IN-1:0]     vec,
  output logic                busy,
  output logic                done,
  output logic [2**N_IN-1:0]  table_out,
  output logic [N_IN:0]       err_count,
  output logic [N_IN-1:0]     first_fail,
  output logic                first_fail_vld,
  output logic                pass
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  localparam logic [3:0]      SETTLE_M1 = 4'(SETTLE - 1);
  localparam logic [N_IN-1:0] LAST_IDX  = '1;

  state_t              state_q, state_d;
  logic [N_IN-1:0]     idx_q, idx_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [2**N_IN-1:0]  table_q, table_d;
  logic [N_IN:0]       err_q, err_d;
  logic [N_IN-1:0]     ff_q, ff_d;
  logic                ffv_q, ffv_d;
  logic                pass_q, pass_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    table_d = table_q;
    err_d   = err_q;
    ff_d    = ff_q;
    ffv_d   = ffv_q;
    pass_d  = pass_q;

    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = S_SETTLE;
          idx_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          table_d = '0;
          err_d   = '0;
          ff_d    = '0;
          ffv_d   = 1'b0;
          pass_d  = 1'b0;
        end
      end

      S_SETTLE: begin
        if (abort) begin
          state_d = S_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b0;
          pass_d  = 1'b0;
        end else if (cnt_q == SETTLE_M1) begin
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      S_SAMPLE: begin
        // abort takes priority: the pending capture and score are dropped
        if (abort) begin
          state_d = S_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b0;
          pass_d  = 1'b0;
        end else begin
          table_d[idx_q] = s_in;
          if (s_in != EXPECT[idx_q]) begin
            err_d = err_q + (N_IN+1)'(1);
            if (!ffv_q) begin
              ff_d  = idx_q;
              ffv_d = 1'b1;
            end
          end
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
          end else begin
            state_d = S_SETTLE;
            idx_d   = idx_q + (N_IN)'(1);
            cnt_d   = '0;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      table_q <= '0;
      err_q   <= '0;
      ff_q    <= '0;
      ffv_q   <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      table_q <= table_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
      ffv_q   <= ffv_d;
      pass_q  <= pass_d;
    end
  end

  assign vec            = idx_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign table_out      = table_q;
  assign err_count      = err_q;
  assign first_fail     = ff_q;
  assign first_fail_vld = ffv_q;
  assign pass           = pass_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: a SETTLE=2 and a SETTLE=1 instance
// driven by a behavioural model of the logic block.
module tb_truth_table_sweeper;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0, abort = 1'b0, s_in;
  logic [3:0]  vec;
  logic        busy, done, ffv, pass;
  logic [15:0] tbl;
  logic [4:0]  errc;
  logic [3:0]  ff;

  logic        start1 = 1'b0, abort1 = 1'b0, s_in1;
  logic [3:0]  vec1;
  logic        busy1, done1, ffv1, pass1;
  logic [15:0] tbl1;
  logic [4:0]  errc1;
  logic [3:0]  ff1;

  int mode = 0;        // 0 model, 1 tied 0, 2 inverted, 3 correct only in SAMPLE
  int edge_cnt = 0;
  int st_edge = 0;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic logic model(input logic [3:0] v);
    return (v[3] & ~v[1]) | (v[2] & ~v[1] & ~v[0]) | (v[3] & v[2] & ~v[0]);
  endfunction

  always_comb begin
    s_in = 1'b0;
    case (mode)
      0: s_in = model(vec);
      1: s_in = 1'b0;
      2: s_in = ~model(vec);
      default: s_in = (((edge_cnt - st_edge) % 3) == 2) ? model(vec) : ~model(vec);
    endcase
  end
  assign s_in1 = model(vec1);

  truth_table_sweeper #(.N_IN(4), .SETTLE(2), .EXPECT(16'h7310)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .s_in(s_in),
    .vec(vec), .busy(busy), .done(done), .table_out(tbl), .err_count(errc),
    .first_fail(ff), .first_fail_vld(ffv), .pass(pass));

  truth_table_sweeper #(.N_IN(4), .SETTLE(1), .EXPECT(16'h7310)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .s_in(s_in1),
    .vec(vec1), .busy(busy1), .done(done1), .table_out(tbl1), .err_count(errc1),
    .first_fail(ff1), .first_fail_vld(ffv1), .pass(pass1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_vec"}, 32'(vec), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_table"}, 32'(tbl), 0);
    chk({tag, "_err"}, 32'(errc), 0);
    chk({tag, "_ff"}, 32'(ff), 0);
    chk({tag, "_ffv"}, 32'(ffv), 0);
    chk({tag, "_pass"}, 32'(pass), 0);
  endtask

  // Pulse start on the main instance; returns at the negedge after edge T0.
  task automatic start_main();
    @(negedge clk);
    start = 1'b1;
    st_edge = edge_cnt + 1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // From the negedge after T0: done must appear exactly after edge T0+48.
  task automatic run_to_done(input string tag);
    repeat (47) @(posedge clk);
    @(negedge clk);
    chk({tag, "_done_early"}, 32'(done), 0);
    chk({tag, "_busy_run"}, 32'(busy), 1);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_done"}, 32'(done), 1);
    chk({tag, "_busy_done"}, 32'(busy), 0);
  endtask

  task automatic chk_result(input string tag, input logic [15:0] t, input logic [4:0] e,
                            input logic [3:0] f, input logic fv, input logic p);
    chk({tag, "_table"}, 32'(tbl), 32'(t));
    chk({tag, "_err"}, 32'(errc), 32'(e));
    chk({tag, "_ff"}, 32'(ff), 32'(f));
    chk({tag, "_ffv"}, 32'(ffv), 32'(fv));
    chk({tag, "_pass"}, 32'(pass), 32'(p));
  endtask

  initial begin
    int ndone, nidle;

    #1 rst_n = 1'b0;
    #1 chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 1: correct block
    mode = 0;
    start_main();
    chk("s1_busy_after_start", 32'(busy), 1);
    chk("s1_vec0", 32'(vec), 0);
    run_to_done("s1");
    chk_result("s1", 16'h7310, 5'd0, 4'd0, 1'b0, 1'b1);
    @(negedge clk);
    chk("s1_done_one_cycle", 32'(done), 0);
    chk("s1_pass_held", 32'(pass), 1);

    // 2: output stuck at 0
    mode = 1;
    start_main();
    chk("s2_pass_cleared", 32'(pass), 0);
    run_to_done("s2");
    chk_result("s2", 16'h0000, 5'd6, 4'd4, 1'b1, 1'b0);

    // 3: inverted output
    mode = 2;
    start_main();
    run_to_done("s3");
    chk_result("s3", 16'h8CEF, 5'd16, 4'd0, 1'b1, 1'b0);

    // sample point: wrong in every SETTLE cycle, right in SAMPLE
    mode = 3;
    start_main();
    run_to_done("samp");
    chk_result("samp", 16'h7310, 5'd0, 4'd0, 1'b0, 1'b1);

    // 4: start held high across a sweep
    mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ndone = 0;
    nidle = 0;
    for (int k = 1; k <= 48; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) ndone++;
      if (!busy) nidle++;
    end
    chk("s4_done_pulses", 32'(ndone), 1);
    chk("s4_busy_gaps", 32'(nidle), 1);
    @(posedge clk);
    @(negedge clk);
    chk("s4_idle_busy", 32'(busy), 0);
    chk("s4_idle_done", 32'(done), 0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("s4_restart_busy", 32'(busy), 1);
    chk("s4_restart_pass_clr", 32'(pass), 0);
    run_to_done("s4b");
    chk_result("s4b", 16'h7310, 5'd0, 4'd0, 1'b0, 1'b1);

    // 5: abort sampled at edge T0+20, with the inverted block
    mode = 2;
    start_main();
    repeat (19) @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    chk("s5_busy", 32'(busy), 0);
    chk("s5_vec", 32'(vec), 0);
    chk("s5_done", 32'(done), 0);
    chk_result("s5", 16'h002F, 5'd6, 4'd0, 1'b1, 1'b0);
    ndone = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("s5_no_done", 32'(ndone), 0);
    chk("s5_table_kept", 32'(tbl), 32'h002F);

    // 5b: asynchronous reset in the middle of a SETTLE cycle
    start_main();
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;

    // 6: SETTLE=1 instance
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    repeat (31) @(posedge clk);
    @(negedge clk);
    chk("s6_done_early", 32'(done1), 0);
    @(posedge clk);
    @(negedge clk);
    chk("s6_done", 32'(done1), 1);
    chk("s6_table", 32'(tbl1), 32'h7310);
    chk("s6_err", 32'(errc1), 0);
    chk("s6_pass", 32'(pass1), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
